// File: rtl/dla_pkg.sv
// Shared DLA types, widths and the int8 requantisation helper.
// Define DLA_RELU_EN to clamp requantised results to [0,127] instead of [-128,127].
`ifndef HWORD
`define HWORD 16
`endif
`ifndef BYTE
`define BYTE 8
`endif
`ifndef MAC_NUM
`define MAC_NUM 9
`endif

package dla_pkg;

  localparam int unsigned MAC_NUM  = `MAC_NUM;
  localparam int unsigned ACC_W    = 32;
  localparam int unsigned SHIFT_W  = 5;
  localparam int unsigned CH_CNT_W = 10;
  localparam int unsigned TREE_W   = `HWORD + 4;

  typedef logic signed [`HWORD-1:0] prod_t;
  typedef logic signed [TREE_W-1:0] tree_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [`BYTE-1:0]  q8_t;
  // One guard bit so the rounding offset can never wrap the accumulator value.
  typedef logic signed [ACC_W:0]    wide_t;

  localparam wide_t Q_MAX = wide_t'(127);
  localparam wide_t Q_MIN = wide_t'(-128);
  localparam wide_t Q_ZERO = wide_t'(0);

  function automatic q8_t requant_sat(input acc_t x, input logic [SHIFT_W-1:0] sh);
    wide_t rnd;
    wide_t r;
    wide_t y;
    q8_t   q;
    rnd = '0;
    if (sh != '0) rnd = wide_t'(1) << (sh - SHIFT_W'(1));
    r = wide_t'(x) + rnd;
    y = r >>> sh;
`ifdef DLA_RELU_EN
    if (y < Q_ZERO)     q = '0;
    else if (y > Q_MAX) q = q8_t'(8'sd127);
    else                q = y[`BYTE-1:0];
`else
    if (y < Q_MIN)      q = q8_t'(-8'sd128);
    else if (y > Q_MAX) q = q8_t'(8'sd127);
    else                q = y[`BYTE-1:0];
`endif
    return q;
  endfunction

endpackage

// File: rtl/adder_tree9.sv
// Combinational signed reduction of one MAC_NUM-product window.
module adder_tree9
  import dla_pkg::*;
(
  input  prod_t i_prod [MAC_NUM],
  output tree_t o_sum
);

  // Four guard bits cover nine int16 terms, so the sum cannot overflow.
  always_comb begin
    o_sum = '0;
    for (int unsigned i = 0; i < MAC_NUM; i++) begin
      o_sum = o_sum + tree_t'(i_prod[i]);
    end
  end

endmodule

// File: rtl/psum_accum.sv
// Partial-sum accumulator: window adder tree, channel accumulation, bias and
// int8 requantisation, with a valid/ready output. Clamp mode set by DLA_RELU_EN.
module psum_accum
  import dla_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  prod_t               mul_result [MAC_NUM],
  input  logic                in_last,
  input  acc_t                bias,
  input  logic [SHIFT_W-1:0]  shift,
  output logic                out_valid,
  input  logic                out_ready,
  output q8_t                 out_data,
  output logic [CH_CNT_W-1:0] ch_cnt
);

  logic                w_adv;
  tree_t               w_tree_sum;
  acc_t                w_acc_next;
  logic [CH_CNT_W-1:0] w_cnt_inc;

  logic                r_a_valid;
  logic                r_a_last;
  tree_t               r_a_sum;
  acc_t                r_acc;
  logic                r_first;
  logic [CH_CNT_W-1:0] r_cnt;
  logic                r_out_valid;
  q8_t                 r_out_data;
  logic [CH_CNT_W-1:0] r_ch_cnt;

  adder_tree9 u_tree (
    .i_prod (mul_result),
    .o_sum  (w_tree_sum)
  );

  // Whole pipeline advances together; only a held output result stalls it.
  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv;

  assign w_acc_next = (r_first ? bias : r_acc) + acc_t'(w_a_sum_ext());
  assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CH_CNT_W'(1);

  function automatic acc_t w_a_sum_ext();
    return acc_t'(r_a_sum);
  endfunction

  // Stage A: registered tree output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_valid <= 1'b0;
      r_a_last  <= 1'b0;
      r_a_sum   <= '0;
    end else if (w_adv) begin
      r_a_valid <= in_valid;
      if (in_valid) begin
        r_a_sum  <= w_tree_sum;
        r_a_last <= in_last;
      end
    end
  end

  // Stage B: accumulate across channels; the last beat emits a result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_first     <= 1'b1;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_ch_cnt    <= '0;
    end else if (w_adv) begin
      r_out_valid <= r_a_valid && r_a_last;
      if (r_a_valid) begin
        if (!r_a_last) begin
          r_acc   <= w_acc_next;
          r_first <= 1'b0;
          r_cnt   <= w_cnt_inc;
        end else begin
          r_out_data <= requant_sat(w_acc_next, shift);
          r_ch_cnt   <= w_cnt_inc;
          r_acc      <= '0;
          r_first    <= 1'b1;
          r_cnt      <= '0;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign ch_cnt    = r_ch_cnt;

endmodule

// File: tb/tb_psum_accum.sv
// Self-checking bench for psum_accum: directed literal cases plus randomized
// groups against a group-level reference model.
module tb_psum_accum;
  import dla_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  prod_t               mul_result [MAC_NUM];
  logic                in_last = 1'b0;
  acc_t                bias = '0;
  logic [SHIFT_W-1:0]  shift = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  q8_t                 out_data;
  logic [CH_CNT_W-1:0] ch_cnt;

  always #5 clk = ~clk;

  psum_accum dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mul_result (mul_result),
    .in_last    (in_last),
    .bias       (bias),
    .shift      (shift),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .ch_cnt     (ch_cnt)
  );

  int n_vec = 0;
  int n_err = 0;
  int q_data[$];
  int q_cnt[$];
  int cur_shift = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready

  // Group-level model state: running exact total and beat count.
  longint g_total = 0;
  int     g_beats = 0;

`ifdef DLA_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_requant(input int acc, input int sh);
    longint r;
    longint y;
    r = longint'(acc) + ((sh == 0) ? 64'sd0 : (64'sd1 <<< (sh - 1)));
    y = r >>> sh;
    if (RELU && y < 0) y = 0;
    if (y < -128) y = -128;
    if (y > 127) y = 127;
    return int'(y);
  endfunction

  task automatic model_accept(input int sum, input bit last, input int b);
    if (g_beats == 0) g_total = longint'(b);
    g_total = g_total + longint'(sum);
    g_beats++;
    if (last) begin
      q_data.push_back(model_requant(int'(g_total), cur_shift));
      q_cnt.push_back((g_beats > 1023) ? 1023 : g_beats);
      g_beats = 0;
      g_total = 0;
    end
  endtask

  task automatic send_beat(input int p[MAC_NUM], input bit last, input int b);
    bit done;
    int sum;
    done = 1'b0;
    sum = 0;
    @(negedge clk);
    for (int i = 0; i < MAC_NUM; i++) begin
      mul_result[i] = prod_t'(p[i]);
      sum += p[i];
    end
    in_last  = last;
    bias     = acc_t'(b);
    in_valid = 1'b1;
    for (int k = 0; k < 300 && !done; k++) begin
      #1;
      if (in_ready) begin
        model_accept(sum, last, b);
        @(posedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) chk("accept_timeout", 0, 1);
    #1 in_valid = 1'b0;
  endtask

  // One idle cycle with in_ready high lets a single-beat group leave stage A.
  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      #1;
      if (in_ready) begin
        @(posedge clk);
        done = 1'b1;
      end
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (q_data.size() != 0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (q_data.size() != 0) chk("idle_timeout", q_data.size(), 0);
    drain();
  endtask

  task automatic set_shift(input int s);
    wait_idle();
    cur_shift = s;
    shift = SHIFT_W'(s);
  endtask

  // Literal-pinned group: p0 on lane 0, prest elsewhere, nb beats, result at t+2.
  task automatic run_lit(input string nm, input int p0, input int prest, input int nb,
                         input int b, input int exp_data, input int exp_cnt);
    int p[MAC_NUM];
    p[0] = p0;
    for (int i = 1; i < MAC_NUM; i++) p[i] = prest;
    for (int j = 0; j < nb; j++) send_beat(p, (j == nb - 1), b);
    @(negedge clk); #2;
    chk({nm, "_lat1_valid"}, out_valid, 0);
    @(negedge clk); #2;
    chk({nm, "_lat2_valid"}, out_valid, 1);
    chk({nm, "_data"}, out_data, exp_data);
    chk({nm, "_cnt"}, ch_cnt, exp_cnt);
    wait_idle();
  endtask

  // Output readiness pattern.
  initial begin
    forever begin
      @(negedge clk);
      out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // Per-cycle compare against the model's ordered result queue.
  initial begin
    bit  prev_stall;
    int  prev_data;
    int  prev_cnt;
    prev_stall = 1'b0;
    prev_data = 0;
    prev_cnt = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        chk("in_ready", in_ready, !out_valid || out_ready);
        if (out_valid) begin
          if (prev_stall) begin
            chk("hold_data", out_data, prev_data);
            chk("hold_cnt", ch_cnt, prev_cnt);
          end
          if (q_data.size() == 0) begin
            chk("spurious_valid", 1, 0);
          end else begin
            chk("out_data", out_data, q_data[0]);
            chk("ch_cnt", ch_cnt, q_cnt[0]);
            if (out_ready) begin
              void'(q_data.pop_front());
              void'(q_cnt.pop_front());
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = int'(out_data);
        prev_cnt   = int'(ch_cnt);
      end
    end
  end

  initial begin
    int p[MAC_NUM];
    int nb;
    int b;
    int pmode;
    for (int i = 0; i < MAC_NUM; i++) mul_result[i] = '0;

    // Reset state
    #1 rst = 1'b1;
    @(negedge clk); #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_ch_cnt", ch_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // Directed groups with literal expectations
    set_shift(0);
    run_lit("single", 2, 2, 1, 0, 18, 1);
    set_shift(4);
    run_lit("three_beat", 100, 100, 3, 60, 127, 3);
    set_shift(0);
    run_lit("neg", -10, -10, 1, 0, RELU ? 0 : -90, 1);
    set_shift(4);
    run_lit("round_pos", 24, 0, 1, 0, 2, 1);
    run_lit("round_neg", -24, 0, 1, 0, RELU ? 0 : -1, 1);
    set_shift(0);
    run_lit("cnt_sat", 0, 0, 1030, 0, 0, 1023);

    // Backpressure: three single-beat groups against a stalled output
    rdy_mode = 2;
    fork
      begin
        for (int g = 1; g <= 3; g++) begin
          for (int i = 0; i < MAC_NUM; i++) p[i] = g * 7 + i;
          send_beat(p, 1'b1, 3);
        end
      end
      begin
        repeat (10) @(negedge clk);
        #2;
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        rdy_mode = 0;
      end
    join
    wait_idle();

    // Back-to-back 2-beat groups, each with its own bias
    for (int i = 0; i < MAC_NUM; i++) p[i] = 3;
    send_beat(p, 1'b0, 10);
    send_beat(p, 1'b1, 10);
    for (int i = 0; i < MAC_NUM; i++) p[i] = -1;
    send_beat(p, 1'b0, 20);
    send_beat(p, 1'b1, 20);
    @(negedge clk); #2;
    chk("b2b_gap_valid", out_valid, 0);
    @(negedge clk); #2;
    chk("b2b_second_valid", out_valid, 1);
    chk("b2b_second_data", out_data, 2);
    chk("b2b_second_cnt", ch_cnt, 2);
    wait_idle();

    // Reset mid-group discards the partial accumulation
    for (int i = 0; i < MAC_NUM; i++) p[i] = 1000 + i;
    send_beat(p, 1'b0, 777);
    send_beat(p, 1'b0, 777);
    @(negedge clk);
    rst = 1'b1;
    g_beats = 0;
    g_total = 0;
    #2;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_ch_cnt", ch_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    run_lit("after_rst", 1, 1, 1, 5, 14, 1);

    // Randomized groups with random backpressure and shift per block
    rdy_mode = 1;
    for (int blk = 0; blk < 12; blk++) begin
      case ($urandom_range(0, 3))
        0:       set_shift(0);
        1:       set_shift(31);
        default: set_shift(int'($urandom_range(1, 15)));
      endcase
      for (int g = 0; g < 15; g++) begin
        nb = int'($urandom_range(1, 4));
        case ($urandom_range(0, 3))
          0:       b = int'($urandom);
          1:       b = 32'sh7FFF_FF00;
          default: b = int'($urandom_range(0, 10000)) - 5000;
        endcase
        pmode = int'($urandom_range(0, 1));
        for (int j = 0; j < nb; j++) begin
          for (int i = 0; i < MAC_NUM; i++) begin
            p[i] = pmode ? int'($urandom_range(0, 65535)) - 32768
                         : int'($urandom_range(0, 100)) - 50;
          end
          if ($urandom_range(0, 3) == 0) @(negedge clk);
          send_beat(p, (j == nb - 1), b);
        end
        if (nb == 1) drain();
      end
    end
    rdy_mode = 0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/psum_accum.md
Name: psum_accum

Overview:
- Consumes the 9 signed int16 products from the multiplier array, one window per beat.
- Reduces each window with a registered adder tree and accumulates across the input channels of one output pixel.
- Adds the bias, rounds, shifts and saturates the result to int8.
- Feeds the output-feature-map writeback stage through a valid/ready handshake.

Parameters:
- MAC_NUM, 9: products per beat; equals the global `MAC_NUM.
- ACC_W, 32: accumulator and bias width.
- SHIFT_W, 5: requantisation shift width.
- CH_CNT_W, 10: width of the beat-count status output.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  product beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- mul_result  in  signed [`HWORD-1:0] x MAC_NUM  products.
- in_last  in  1  last input-channel beat of the current output pixel.
- bias  in  signed ACC_W  pixel bias; stable from the group's first beat until its last beat reaches stage B.
- shift  in  SHIFT_W  right-shift amount; quasi-static.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  signed [`BYTE-1:0]  requantised result.
- ch_cnt  out  CH_CNT_W  beats accumulated in the group being output; saturates at all-ones.

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high. Reset clears all state:
  - out_valid=0, out_data=0, ch_cnt=0.
  - Stage A valid=0, acc=0, first=1, beat counter=0.
- Global advance: adv = !out_valid || out_ready. in_ready = adv, combinational.
- Stage A (tree), on adv:
  - a_valid <= in_valid.
  - When in_valid: a_sum <= signed sum of all MAC_NUM products, width `HWORD+4, no overflow possible. a_last <= in_last.
- Stage B (accumulate), on adv && a_valid:
  - acc_next = (first ? bias : acc) + sext(a_sum), ACC_W wide, two's-complement wrap.
  - beat counter increments, saturating.
  - If !a_last: acc <= acc_next, first <= 0.
  - If a_last:
    - out_data <= requant(acc_next), out_valid <= 1, ch_cnt <= counter+1 (saturating).
    - first <= 1, counter <= 0, acc <= 0.
  - A single-beat group (first && a_last) is legal.
- requant(x):
  - r = x + (shift==0 ? 0 : 1<<(shift-1)).
  - y = r >>> shift (arithmetic).
  - Clamp per the Optional Feature section.
- Output handshake:
  - On out_valid && out_ready with no new result, out_valid <= 0.
  - Handshake and new result in the same cycle: new result loads, out_valid stays 1.
  - out_data is held stable while out_valid && !out_ready.
- Latency: a last beat accepted in cycle t gives out_valid in cycle t+2. Throughput is 1 beat/cycle with out_ready=1.
- Stall: while out_valid && !out_ready, both stages freeze, in_ready=0, and no beat is lost or duplicated.
- Reset mid-group: the partial accumulation is discarded; the next beat starts a new group.

Optional Feature:
- Macro: DLA_RELU_EN.
- Defined: y<0 gives 0; y>127 gives 127.
- Undefined: signed saturation of y to [-128,127].
- Either way, the unsaturated value is never exposed on a port.

Decomposition:
- Shared package dla_pkg:
  - typedefs prod_t (signed `HWORD), tree_t (signed `HWORD+4), acc_t (signed ACC_W), q8_t (signed `BYTE).
  - function requant_sat(acc_t, shift) returning q8_t, with the DLA_RELU_EN clamp inside.
- Sub-module adder_tree9: combinational 9-input signed sum; stage-A registers stay in psum_accum.

Test Plan:
- 1. Single-beat group: all 9 products=2, bias=0, shift=0, in_last=1 at t → out_data=18, out_valid at t+2, ch_cnt=1.
- 2. Three-beat group, products all 100, bias=60, shift=4: (2760+8)>>>4=173 → out_data=127; ch_cnt=3.
- 3. Negative and rounding:
  - products all -10, bias 0, shift 0 → -90 without DLA_RELU_EN, 0 with it.
  - sum 24, shift 4 → 2.
  - sum -24, shift 4 → -1 (no ReLU).
- 4. Backpressure: out_ready=0 for 10 cycles while 3 single-beat groups stream in:
  - in_ready drops after the first result.
  - Results emerge in order, unchanged, after out_ready=1.
- 5. Back-to-back groups with out_ready=1: two consecutive 2-beat groups → two results in consecutive-beat cadence; the second group uses its own bias.
- 6. rst asserted mid-group after 2 beats, then a 1-beat group of products=1 with bias=5 → out_data=14; no residue from the discarded beats.
